// File: rtl/max_unpool.sv
// Streaming max-unpooling: buffers one pooled row of {data, argmax}, then scatters
// each value into its POOL_SIZE x POOL_SIZE window with zero fill, row-major, channel fastest.
module max_unpool #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned IN_WIDTH    = 4,
  parameter int unsigned IN_CHANNELS = 1,
  parameter int unsigned POOL_SIZE   = 2,
  localparam int unsigned IDX_W =
    ($clog2(POOL_SIZE * POOL_SIZE) < 1) ? 1 : $clog2(POOL_SIZE * POOL_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [IDX_W-1:0]      in_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam int unsigned DEPTH = IN_WIDTH * IN_CHANNELS;
  localparam int unsigned OUT_W = IN_WIDTH * POOL_SIZE;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned XW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned CW    = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
  localparam int unsigned MW    = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  localparam int unsigned RW    = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;

  typedef enum logic {FILL, EMIT} state_e;

  state_e                state_q;
  logic [AW-1:0]         fill_q;
  logic [RW-1:0]         row_q;
  logic [MW-1:0]         m_q;
  logic [XW-1:0]         x_q;
  logic [CW-1:0]         c_q;
  logic                  out_valid_q;
  logic                  out_last_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  logic [DATA_WIDTH-1:0] buf_data_q [DEPTH];
  logic [IDX_W-1:0]      buf_idx_q  [DEPTH];

  logic                  in_fire, out_fire, fill_last;
  logic                  last_c, last_x, last_m, emit_done;
  logic [MW-1:0]         nxt_m_d, ld_m_d;
  logic [XW-1:0]         nxt_x_d, ld_x_d;
  logic [CW-1:0]         nxt_c_d, ld_c_d;
  logic [AW-1:0]         ld_addr_d;
  logic [31:0]           ld_pos_d;
  logic [DATA_WIDTH-1:0] ent_data_d, ld_data_d;
  logic [IDX_W-1:0]      ent_idx_d;
  logic                  ld_last_d;

  assign in_ready  = (state_q == FILL) && !rst;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign fill_last = (fill_q == AW'(DEPTH - 1));

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

  // Row buffer write; contents are left unreset on purpose.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      buf_data_q[fill_q] <= in_data;
      buf_idx_q[fill_q]  <= in_idx;
    end
  end

  // Next output position and the beat value loaded there.
  always_comb begin
    last_c    = (c_q == CW'(IN_CHANNELS - 1));
    last_x    = (x_q == XW'(OUT_W - 1));
    last_m    = (m_q == MW'(POOL_SIZE - 1));
    emit_done = last_c && last_x && last_m;

    nxt_c_d = last_c ? '0 : c_q + CW'(1);
    nxt_x_d = x_q;
    if (last_c) nxt_x_d = last_x ? '0 : x_q + XW'(1);
    nxt_m_d = (last_c && last_x) ? m_q + MW'(1) : m_q;

    ld_m_d = nxt_m_d;
    ld_x_d = nxt_x_d;
    ld_c_d = nxt_c_d;
    if (state_q == FILL) begin
      ld_m_d = '0;
      ld_x_d = '0;
      ld_c_d = '0;
    end

    ld_addr_d = AW'((32'(ld_x_d) / POOL_SIZE) * IN_CHANNELS + 32'(ld_c_d));
    ld_pos_d  = 32'(ld_m_d) * POOL_SIZE + 32'(ld_x_d) % POOL_SIZE;

    // A single-entry row is read on the same edge it is written.
    ent_data_d = buf_data_q[ld_addr_d];
    ent_idx_d  = buf_idx_q[ld_addr_d];
    if ((state_q == FILL) && (ld_addr_d == fill_q)) begin
      ent_data_d = in_data;
      ent_idx_d  = in_idx;
    end

    ld_data_d = (32'(ent_idx_d) == ld_pos_d) ? ent_data_d : '0;
    ld_last_d = (ld_m_d == MW'(POOL_SIZE - 1)) && (ld_x_d == XW'(OUT_W - 1)) &&
                (ld_c_d == CW'(IN_CHANNELS - 1)) && (row_q == RW'(IN_WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      fill_q      <= '0;
      row_q       <= '0;
      m_q         <= '0;
      x_q         <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        FILL: begin
          if (in_fire) begin
            if (fill_last) begin
              fill_q      <= '0;
              state_q     <= EMIT;
              m_q         <= ld_m_d;
              x_q         <= ld_x_d;
              c_q         <= ld_c_d;
              out_valid_q <= 1'b1;
              out_data_q  <= ld_data_d;
              out_last_q  <= ld_last_d;
            end else begin
              fill_q <= fill_q + AW'(1);
            end
          end
        end
        EMIT: begin
          if (out_fire) begin
            if (emit_done) begin
              state_q     <= FILL;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              m_q         <= '0;
              x_q         <= '0;
              c_q         <= '0;
              row_q       <= (row_q == RW'(IN_WIDTH - 1)) ? '0 : row_q + RW'(1);
            end else begin
              m_q        <= ld_m_d;
              x_q        <= ld_x_d;
              c_q        <= ld_c_d;
              out_data_q <= ld_data_d;
              out_last_q <= ld_last_d;
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_max_unpool.sv
// Bench for max_unpool: single-channel and two-channel instances checked against a
// full-resolution frame model built from the unpooling rule.
module tb_max_unpool;

  localparam int unsigned DW  = 16;
  localparam int unsigned IW  = 2;
  localparam int unsigned PS  = 2;
  localparam int unsigned IXW = 2;
  localparam int unsigned OW  = IW * PS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           in_valid  [2];
  logic           in_ready  [2];
  logic           out_valid [2];
  logic           out_ready [2];
  logic           out_last  [2];
  logic [DW-1:0]  in_data   [2];
  logic [DW-1:0]  out_data  [2];
  logic [IXW-1:0] in_idx    [2];

  max_unpool #(.DATA_WIDTH(DW), .IN_WIDTH(IW), .IN_CHANNELS(1), .POOL_SIZE(PS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_idx(in_idx[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_last(out_last[0])
  );

  max_unpool #(.DATA_WIDTH(DW), .IN_WIDTH(IW), .IN_CHANNELS(2), .POOL_SIZE(PS)) dut_mc (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_idx(in_idx[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_last(out_last[1])
  );

  int checks = 0;
  int errors = 0;

  // Pooled frame: [row][col*nch + c]
  logic [DW-1:0]  fd [IW][IW*2];
  logic [IXW-1:0] fi [IW][IW*2];
  logic [DW:0]    exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: place each value in the full-resolution map, zero elsewhere, then flatten.
  task automatic model_frame(input int nch);
    logic [DW-1:0] full [OW][OW][2];
    int id;
    for (int y = 0; y < OW; y++)
      for (int x = 0; x < OW; x++)
        for (int c = 0; c < 2; c++) full[y][x][c] = '0;
    for (int r = 0; r < IW; r++)
      for (int col = 0; col < IW; col++)
        for (int c = 0; c < nch; c++) begin
          id = int'(fi[r][col*nch+c]);
          if (id < PS * PS) full[r*PS + id/PS][col*PS + id%PS][c] = fd[r][col*nch+c];
        end
    for (int y = 0; y < OW; y++)
      for (int x = 0; x < OW; x++)
        for (int c = 0; c < nch; c++)
          exp_q.push_back({(y == OW-1) && (x == OW-1) && (c == nch-1), full[y][x][c]});
  endtask

  task automatic send_row(input int s, input int r, input int nch, input int gap);
    int cyc;
    for (int k = 0; k < IW * nch; k++) begin
      in_valid[s] = 1'b1;
      in_data[s]  = fd[r][k];
      in_idx[s]   = fi[r][k];
      cyc = 0;
      while (in_ready[s] !== 1'b1 && cyc < 50) begin
        @(posedge clk); #1; cyc++;
      end
      chk("in_ready_fill", 32'(in_ready[s]), 32'd1);
      @(posedge clk); #1;
      in_valid[s] = 1'b0;
      if (k != IW * nch - 1) begin
        repeat (gap) begin @(posedge clk); #1; end
        chk("no_out_in_fill", 32'(out_valid[s]), 32'd0);
      end
    end
    chk("emit_latency", 32'(out_valid[s]), 32'd1);
    chk("in_ready_emit", 32'(in_ready[s]), 32'd0);
  endtask

  task automatic collect(input int s, input int n, input bit bp);
    int got = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [DW:0] held, e;
    while (got < n && cyc < 400) begin
      if (stalled) chk("stall_hold", {out_valid[s], out_last[s], out_data[s]}, {1'b1, held});
      out_ready[s] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid[s] === 1'b1) begin
        if (out_ready[s]) begin
          chk("exp_avail", 32'(exp_q.size() != 0), 32'd1);
          e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
          chk("out_data", 32'(out_data[s]), 32'(e[DW-1:0]));
          chk("out_last", 32'(out_last[s]), 32'(e[DW]));
          got++;
          stalled = 1'b0;
        end else begin
          held = {out_last[s], out_data[s]};
          stalled = 1'b1;
        end
      end
      @(posedge clk); #1; cyc++;
    end
    out_ready[s] = 1'b0;
    chk("collect_done", 32'(got), 32'(n));
  endtask

  task automatic run_frame(input int s, input int nch, input int gap, input bit bp);
    model_frame(nch);
    for (int r = 0; r < IW; r++) begin
      send_row(s, r, nch, gap);
      collect(s, PS * PS * IW * nch, bp);
      chk("row_end_valid", 32'(out_valid[s]), 32'd0);
      chk("row_end_ready", 32'(in_ready[s]), 32'd1);
    end
  endtask

  task automatic set_frame1();
    fd[0][0] = 16'h0005; fi[0][0] = 2'd3;
    fd[0][1] = 16'h0007; fi[0][1] = 2'd0;
    fd[1][0] = 16'h00AA; fi[1][0] = 2'd1;
    fd[1][1] = 16'h00BB; fi[1][1] = 2'd2;
  endtask

  task automatic set_random(input int nch);
    for (int r = 0; r < IW; r++)
      for (int k = 0; k < IW * nch; k++) begin
        fd[r][k] = DW'($urandom);
        fi[r][k] = IXW'($urandom_range(0, 3));
      end
  endtask

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      in_valid[s] = 1'b0; in_data[s] = '0; in_idx[s] = '0; out_ready[s] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_out_valid", 32'(out_valid[s]), 32'd0);
      chk("rst_out_last", 32'(out_last[s]), 32'd0);
      chk("rst_out_data", 32'(out_data[s]), 32'd0);
      chk("rst_in_ready", 32'(in_ready[s]), 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready[0]), 32'd1);
    @(posedge clk); #1;

    set_frame1(); run_frame(0, 1, 0, 1'b0);
    set_frame1(); run_frame(0, 1, 0, 1'b1);
    set_frame1(); run_frame(0, 1, 3, 1'b0);

    // Reset after the second output beat of row 0
    set_frame1(); model_frame(1);
    send_row(0, 0, 1, 0);
    collect(0, 2, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", 32'(out_valid[0]), 32'd0);
    chk("midrst_in_ready", 32'(in_ready[0]), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_release_ready", 32'(in_ready[0]), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("midrst_idle", 32'(out_valid[0]), 32'd0);
    end
    exp_q.delete();
    set_frame1(); run_frame(0, 1, 0, 1'b0);

    for (int f = 0; f < 4; f++) begin
      set_random(1);
      run_frame(0, 1, $urandom_range(0, 2), 1'b1);
    end

    set_random(2);
    fd[0][0] = 16'h0011; fi[0][0] = 2'd0;
    fd[0][1] = 16'h0022; fi[0][1] = 2'd1;
    fd[0][2] = 16'h0033; fi[0][2] = 2'd2;
    fd[0][3] = 16'h0044; fi[0][3] = 2'd3;
    run_frame(1, 2, 0, 1'b0);
    for (int f = 0; f < 2; f++) begin
      set_random(2);
      run_frame(1, 2, $urandom_range(0, 2), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
